// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
//   Default prescaler / stability settings for 125 MHz and 200 MHz core clocks
//   (100 us sample tick, 5 ms acceptance window) and a counter-width helper.
package sw_debounce_pkg;

    localparam int unsigned TICK_DIV_125MHZ   = 12500;
    localparam int unsigned STABLE_CNT_125MHZ = 50;
    localparam int unsigned TICK_DIV_200MHZ   = 20000;
    localparam int unsigned STABLE_CNT_200MHZ = 50;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// Single-channel switch debouncer.
//   clk        core clock
//   resetn     synchronous active-low reset
//   tick       shared sample strobe from the prescaler
//   sw_in      raw asynchronous switch pin
//   chg_clr    level-sensitive clear of chg_sticky
//   sw_db      debounced level
//   sw_rise    one-clk pulse when sw_db goes 0->1
//   sw_fall    one-clk pulse when sw_db goes 1->0
//   chg_sticky latched "level changed" flag
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = STABLE_CNT_125MHZ
) (
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic sw_in,
    input  logic chg_clr,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall,
    output logic chg_sticky
);

    localparam int unsigned   CW      = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          sticky_q, sticky_d;

    always_comb begin
        cnt_d    = cnt_q;
        db_d     = db_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        sticky_d = sticky_q;

        if (tick) begin
            if (sync2_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                db_d   = sync2_q;
                cnt_d  = '0;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // The flag is set on the same edge as sw_db changes, and a clear
        // arriving while the rise/fall pulse is still visible loses to it.
        if (rise_d || fall_d || rise_q || fall_q) begin
            sticky_d = 1'b1;
        end else if (chg_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sync1_q  <= sw_in;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign sw_db      = db_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign chg_sticky = sticky_q;

endmodule

// File: rtl/sw_debounce.sv
// Debouncer/synchroniser for the board slide switches feeding the GPIO word.
//   clk        core clock
//   resetn     synchronous active-low reset
//   sw_in      raw switch pins [WIDTH]
//   chg_clr    per-channel clear of chg_sticky [WIDTH]
//   sw_db      debounced levels [WIDTH]
//   sw_rise    one-clk rise pulses [WIDTH]
//   sw_fall    one-clk fall pulses [WIDTH]
//   chg_sticky latched change flags [WIDTH]
//   irq        OR of all chg_sticky bits
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TICK_DIV   = TICK_DIV_125MHZ,
    parameter int unsigned STABLE_CNT = STABLE_CNT_125MHZ
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [WIDTH-1:0] chg_clr,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] chg_sticky,
    output logic             irq
);

    localparam int unsigned   PW      = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    // With TICK_DIV == 1 the counter sits at 0 == PRE_MAX, so tick is constant 1.
    assign tick  = (pre_q == PRE_MAX);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sw_debounce_ch #(
            .STABLE_CNT(STABLE_CNT)
        ) u_ch (
            .clk       (clk),
            .resetn    (resetn),
            .tick      (tick),
            .sw_in     (sw_in[i]),
            .chg_clr   (chg_clr[i]),
            .sw_db     (sw_db[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i]),
            .chg_sticky(chg_sticky[i])
        );
    end

    assign irq = |chg_sticky;

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Debounces and synchronises the WIDTH board slide switches before they reach the CPU GPIO input word.
- Sits between the board switch pins and the core's io_i[15:0] input.
- Produces clean levels, one-cycle rise/fall event pulses, and sticky change flags with an interrupt summary that firmware can poll or clear.
- Runs in the 125 MHz core clock domain.

Parameters:
- WIDTH, 16, number of switch channels.
- TICK_DIV, 12500, clk cycles per sample tick (100 us at 125 MHz); legal range >= 1.
- STABLE_CNT, 50, consecutive differing ticks required before a level is accepted (5 ms); legal range >= 1.

Ports:
- clk  in  1  core clock.
- resetn  in  1  synchronous active-low reset; one clock (clk), synchronous active-low reset (resetn).
- sw_in  in  WIDTH  raw asynchronous switch pins.
- chg_clr  in  WIDTH  per-channel clear of chg_sticky; level-sensitive, sampled each clk.
- sw_db  out  WIDTH  debounced level.
- sw_rise  out  WIDTH  one-clk pulse when sw_db goes 0->1.
- sw_fall  out  WIDTH  one-clk pulse when sw_db goes 1->0.
- chg_sticky  out  WIDTH  latched "level changed" flag per channel.
- irq  out  1  OR-reduction of chg_sticky.

Behaviour:
- Reset (resetn=0 at a clk edge): the following all go to 0 — sync flops, prescaler, per-channel counters, sw_db, sw_rise, sw_fall, chg_sticky, irq. Reset asserted mid-count discards all progress.
- Synchroniser: 2-flop per bit; sync = second stage. Adds 2 clk of latency.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick=1 for the single clk where count==TICK_DIV-1. With TICK_DIV=1, tick is always 1. Counter width is clog2(TICK_DIV), minimum 1.
- Per channel, evaluated only on tick:
  - sync==sw_db: cnt<=0.
  - sync!=sw_db and cnt<STABLE_CNT-1: cnt<=cnt+1.
  - sync!=sw_db and cnt==STABLE_CNT-1: sw_db<=sync, cnt<=0.
  - cnt never exceeds STABLE_CNT-1. Width is clog2(STABLE_CNT), minimum 1.
- Any tick on which sync matches sw_db restarts the count. A glitch shorter than STABLE_CNT ticks therefore never propagates.
- sw_rise/sw_fall: registered and asserted in the same clk that sw_db takes its new value; high for exactly 1 clk. At most one of the two is high per channel per clk.
- chg_sticky[i]:
  - set when sw_rise[i]|sw_fall[i];
  - else cleared when chg_clr[i];
  - set wins over a simultaneous clear;
  - holds otherwise.
- irq = |chg_sticky, combinational from registers. No extra latency relative to chg_sticky.
- Power-up with a switch already at 1: sw_db starts at 0 after reset, then rises with a normal sw_rise pulse and sets chg_sticky. Firmware clears the startup flags.
- Latency from a stable sw_in change to sw_db: 2 + (STABLE_CNT-1)*TICK_DIV + 1 clk minimum, 2 + STABLE_CNT*TICK_DIV clk maximum.
- Channels are fully independent. They share only the synchroniser timing and the tick.

Decomposition:
- Shared package: default TICK_DIV/STABLE_CNT constants for 125 MHz and 200 MHz clocks, and a clog2-based width helper.
- One natural sub-module, sw_debounce_ch. It is single-bit and contains the sync flops, cnt, sw_db, rise/fall and sticky logic.
- sw_debounce holds the shared prescaler and a generate loop of WIDTH channel instances.

Test Plan (TICK_DIV=4, STABLE_CNT=3 unless noted):
- Reset release with sw_in=0 held -> all outputs 0 indefinitely; irq=0.
- sw_in[0] 0->1 and held -> sw_db[0]=1 between 11 and 14 clk after the change. sw_rise[0] is high for exactly that 1 clk. chg_sticky[0]=1 and irq=1 from the same clk. Other bits stay 0.
- sw_in[3] high for 6 clk then low (fewer than 3 ticks) -> sw_db[3], sw_rise[3] and chg_sticky[3] stay 0. The channel counter reads 0 after the next tick.
- With chg_sticky[5]=1 and sw_db[5]=1, drop sw_in[5]. Pulse chg_clr[5] on exactly the sw_fall[5] clk -> chg_sticky[5] stays 1. A later 1-clk chg_clr[5] clears it to 0 and irq falls to 0 in the same clk.
- Assert resetn=0 for 1 clk after 2 of 3 ticks of a pending change, then release -> sw_db stays 0. The change needs a full fresh 3 ticks before sw_db rises.
- TICK_DIV=1, STABLE_CNT=1, all 16 bits toggling together 0x0000->0xA5A5 -> sw_db=0xA5A5 exactly 3 clk later, sw_rise=0xA5A5 for 1 clk, sw_fall=0.
